// File: rtl/player_input_conditioner_if.sv
// player_input_conditioner_if: req/gnt handshake between the button front end and the game FSM.
interface player_input_conditioner_if;
    logic arm_in;
    logic gnt1_in;
    logic gnt2_in;
    logic req1_out;
    logic req2_out;
    logic false_start1_out;
    logic false_start2_out;
    modport master (
        input  arm_in, gnt1_in, gnt2_in,
        output req1_out, req2_out, false_start1_out, false_start2_out
    );
    modport slave (
        output arm_in, gnt1_in, gnt2_in,
        input  req1_out, req2_out, false_start1_out, false_start2_out
    );
endinterface

// File: rtl/player_input_conditioner.sv
// player_input_conditioner: sync, debounce and request FSM for two active-low player buttons.
// Optional sticky false-start flags enabled by ARBITER_INPUT_FALSE_START_EN.
module player_input_conditioner #(
    parameter int CLOCK_FREQ     = 12000000,
    parameter int DEBOUNCE_COUNT = CLOCK_FREQ / 1000
) (
    input logic                        clk,
    input logic                        rst_in_n,
    input logic                        btn1_in_n,
    input logic                        btn2_in_n,
    player_input_conditioner_if.master bus
);
    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
    typedef enum logic [1:0] {IDLE, REQ, GRANTED, LOCKED} state_t;
    logic [1:0] btn_n, gnt, req, fs;
    assign btn_n = {btn2_in_n, btn1_in_n};
    assign gnt = {bus.gnt2_in, bus.gnt1_in};
    assign bus.req1_out = req[0];
    assign bus.req2_out = req[1];
    assign bus.false_start1_out = fs[0];
    assign bus.false_start2_out = fs[1];
`ifdef ARBITER_INPUT_FALSE_START_EN
    logic arm_q;
    always_ff @(posedge clk or negedge rst_in_n)
        if (!rst_in_n) arm_q <= 1'b1;
        else arm_q <= bus.arm_in;
`endif
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [1:0] sync;
        logic stable;
        logic [CW-1:0] cnt;
        logic pressed;
        logic req_r;
        state_t state, state_nx;
        assign pressed = ~stable;
        always_ff @(posedge clk or negedge rst_in_n)
            if (!rst_in_n) begin
                sync <= 2'b11;
                stable <= 1'b1;
                cnt <= '0;
                state <= IDLE;
                req_r <= 1'b0;
            end else begin
                sync <= {sync[0], btn_n[c]};
                if (sync[1] == stable) cnt <= '0;
                else if (cnt == CW'(DEBOUNCE_COUNT - 1)) begin
                    stable <= sync[1];
                    cnt <= '0;
                end else cnt <= cnt + 1'b1;
                state <= state_nx;
                req_r <= state_nx == REQ;
            end
        // REQ precedence: grant, then release, then disarm
        always_comb begin
            state_nx = state;
            case (state)
                IDLE:    if (pressed) state_nx = bus.arm_in ? REQ : LOCKED;
                REQ:     state_nx = gnt[c] ? GRANTED : !pressed ? IDLE : !bus.arm_in ? LOCKED : REQ;
                default: if (!pressed) state_nx = IDLE;
            endcase
        end
        assign req[c] = req_r;
`ifdef ARBITER_INPUT_FALSE_START_EN
        logic fs_r;
        always_ff @(posedge clk or negedge rst_in_n)
            if (!rst_in_n) fs_r <= 1'b0;
            else if (state == IDLE && pressed && !bus.arm_in) fs_r <= 1'b1;
            else if (bus.arm_in && !arm_q) fs_r <= 1'b0;
        assign fs[c] = fs_r;
`else
        assign fs[c] = 1'b0;
`endif
    end
endmodule
